// File: rtl/reg_xfer_seq.sv
// Register-transfer sequencer: copies or exchanges two 8-bit register slices by
// driving one-hot read/write strobes and write data, then pulses done (and err).
module reg_xfer_seq #(
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned SEL_W    = 3
) (
    input  logic                clk50M_i,
    input  logic                rst_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [SEL_W-1:0]    req_src_i,
    input  logic [SEL_W-1:0]    req_dst_i,
    input  logic                req_swap_i,
    output logic [NUM_REGS-1:0] rd_en_o,
    output logic [NUM_REGS-1:0] wr_en_o,
    input  logic [7:0]          bus_i,
    output logic [7:0]          bus_o,
    output logic                done_o,
    output logic                err_o
);

    localparam int unsigned CMP_W = SEL_W + 1;
    localparam logic [CMP_W-1:0] NREGS_CMP = CMP_W'(NUM_REGS);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD_A = 3'd1;
    localparam logic [2:0] ST_RD_B = 3'd2;
    localparam logic [2:0] ST_WR_B = 3'd3;
    localparam logic [2:0] ST_WR_A = 3'd4;
    localparam logic [2:0] ST_FIN  = 3'd5;

    logic [2:0]          state_q, state_d;
    logic [SEL_W-1:0]    src_q, src_d;
    logic [SEL_W-1:0]    dst_q, dst_d;
    logic                swap_q, swap_d;
    logic                err_flag_q, err_flag_d;
    logic [7:0]          tmp_a_q, tmp_a_d;
    logic [7:0]          tmp_b_q, tmp_b_d;
    logic [NUM_REGS-1:0] rd_en_q, rd_en_d;
    logic [NUM_REGS-1:0] wr_en_q, wr_en_d;
    logic [7:0]          bus_q, bus_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                ready_q, ready_d;

    function automatic logic [NUM_REGS-1:0] sel_onehot(input logic [SEL_W-1:0] idx);
        return NUM_REGS'(1) << idx;
    endfunction

    // Next state, then outputs derived from the state being entered so they register alongside it
    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        swap_d     = swap_q;
        err_flag_d = err_flag_q;
        tmp_a_d    = tmp_a_q;
        tmp_b_d    = tmp_b_q;
        bus_d      = bus_q;
        rd_en_d    = '0;
        wr_en_d    = '0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid_i && ready_q) begin
                    src_d  = req_src_i;
                    dst_d  = req_dst_i;
                    swap_d = req_swap_i;
                    if (({1'b0, req_src_i} >= NREGS_CMP) || ({1'b0, req_dst_i} >= NREGS_CMP)) begin
                        err_flag_d = 1'b1;
                        state_d    = ST_FIN;
                    end else begin
                        err_flag_d = 1'b0;
                        state_d    = ST_RD_A;
                    end
                end
            end
            ST_RD_A: begin
                tmp_a_d = bus_i;
                state_d = swap_q ? ST_RD_B : ST_WR_B;
            end
            ST_RD_B: begin
                tmp_b_d = bus_i;
                state_d = ST_WR_B;
            end
            ST_WR_B: state_d = swap_q ? ST_WR_A : ST_FIN;
            ST_WR_A: state_d = ST_FIN;
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // tmp_*_d forwards the value sampled this cycle into the following write
        case (state_d)
            ST_RD_A: rd_en_d = sel_onehot(src_d);
            ST_RD_B: rd_en_d = sel_onehot(dst_d);
            ST_WR_B: begin
                wr_en_d = sel_onehot(dst_d);
                bus_d   = tmp_a_d;
            end
            ST_WR_A: begin
                wr_en_d = sel_onehot(src_d);
                bus_d   = tmp_b_d;
            end
            default: ;
        endcase

        done_d  = (state_d == ST_FIN);
        err_d   = done_d & err_flag_d;
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk50M_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            swap_q     <= 1'b0;
            err_flag_q <= 1'b0;
            tmp_a_q    <= 8'h00;
            tmp_b_q    <= 8'h00;
            rd_en_q    <= '0;
            wr_en_q    <= '0;
            bus_q      <= 8'h00;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            swap_q     <= swap_d;
            err_flag_q <= err_flag_d;
            tmp_a_q    <= tmp_a_d;
            tmp_b_q    <= tmp_b_d;
            rd_en_q    <= rd_en_d;
            wr_en_q    <= wr_en_d;
            bus_q      <= bus_d;
            done_q     <= done_d;
            err_q      <= err_d;
            ready_q    <= ready_d;
        end
    end

    assign req_ready_o = ready_q;
    assign rd_en_o     = rd_en_q;
    assign wr_en_o     = wr_en_q;
    assign bus_o       = bus_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_reg_xfer_seq.sv
// Bench for reg_xfer_seq: an 8-slice and a 6-slice instance share a modelled
// register file; results are checked against a transfer-level reference.
module tb_reg_xfer_seq;

    logic       clk;
    logic       rst;
    logic       v8, v6;
    logic [2:0] src, dst;
    logic       swp;
    logic [7:0] bus_in;

    logic       rdy8, done8, err8;
    logic [7:0] rd8, wr8, bus8;
    logic       rdy6, done6, err6;
    logic [5:0] rd6, wr6;
    logic [7:0] bus6;

    int total = 0;
    int bad   = 0;

    logic [7:0] regs   [8];
    logic [7:0] ld_val [8];
    logic       ld;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    reg_xfer_seq #(.NUM_REGS(8), .SEL_W(3)) dut8 (
        .clk50M_i(clk), .rst_i(rst), .req_valid_i(v8), .req_ready_o(rdy8),
        .req_src_i(src), .req_dst_i(dst), .req_swap_i(swp),
        .rd_en_o(rd8), .wr_en_o(wr8), .bus_i(bus_in), .bus_o(bus8),
        .done_o(done8), .err_o(err8)
    );

    reg_xfer_seq #(.NUM_REGS(6), .SEL_W(3)) dut6 (
        .clk50M_i(clk), .rst_i(rst), .req_valid_i(v6), .req_ready_o(rdy6),
        .req_src_i(src), .req_dst_i(dst), .req_swap_i(swp),
        .rd_en_o(rd6), .wr_en_o(wr6), .bus_i(bus_in), .bus_o(bus6),
        .done_o(done6), .err_o(err6)
    );

    // Register-slice model: the strobed slice drives the bus, writes land on the edge
    always_comb begin
        bus_in = 8'h00;
        for (int i = 0; i < 8; i++) if (rd8[i]) bus_in = regs[i];
        for (int i = 0; i < 6; i++) if (rd6[i]) bus_in = regs[i];
    end

    always @(posedge clk) begin
        if (ld) begin
            for (int i = 0; i < 8; i++) regs[i] <= ld_val[i];
        end else begin
            for (int i = 0; i < 8; i++) if (wr8[i]) regs[i] <= bus8;
            for (int i = 0; i < 6; i++) if (wr6[i]) regs[i] <= bus6;
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (!rst) begin
            total++;
            if ($countones({rd8, wr8}) > 1 || $countones({rd6, wr6}) > 1) begin
                bad++;
                $display("FAIL strobe_onehot: rd8=%h wr8=%h rd6=%h wr6=%h", rd8, wr8, rd6, wr6);
            end
        end
    endtask

    task automatic randomize_ld();
        for (int i = 0; i < 8; i++) ld_val[i] = 8'($urandom);
    endtask

    task automatic load_regs();
        ld = 1'b1;
        tick();
        ld = 1'b0;
    endtask

    // Issue one request and check latency, err, strobe counts and final slice contents
    task automatic xfer(input bit d6, input logic [2:0] s, input logic [2:0] d, input logic sw,
                        input int exp_lat, input logic exp_err, input string tag);
        logic [7:0] e [8];
        int lat, n_rd, n_wr;
        randomize_ld();
        load_regs();
        for (int i = 0; i < 8; i++) e[i] = ld_val[i];
        if (!exp_err) begin
            if (sw) begin
                e[s] = ld_val[d];
                e[d] = ld_val[s];
            end else begin
                e[d] = ld_val[s];
            end
        end
        cmp({tag, "_ready"}, 32'(d6 ? rdy6 : rdy8), 32'(1));
        src = s; dst = d; swp = sw;
        if (d6) v6 = 1'b1; else v8 = 1'b1;
        tick();
        v6 = 1'b0; v8 = 1'b0;
        src = 3'($urandom); dst = 3'($urandom); swp = 1'($urandom);
        lat = 1; n_rd = 0; n_wr = 0;
        while (!(d6 ? done6 : done8) && lat < 20) begin
            n_rd += d6 ? $countones(rd6) : $countones(rd8);
            n_wr += d6 ? $countones(wr6) : $countones(wr8);
            tick();
            lat++;
        end
        cmp({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        cmp({tag, "_err"}, 32'(d6 ? err6 : err8), 32'(exp_err));
        cmp({tag, "_nrd"}, 32'(n_rd), 32'(exp_err ? 0 : (sw ? 2 : 1)));
        cmp({tag, "_nwr"}, 32'(n_wr), 32'(exp_err ? 0 : (sw ? 2 : 1)));
        cmp({tag, "_regs"}, {regs[7], regs[6], regs[5], regs[4]} ^ {regs[3], regs[2], regs[1], regs[0]},
            {e[7], e[6], e[5], e[4]} ^ {e[3], e[2], e[1], e[0]});
        cmp({tag, "_reg_dst"}, 32'(regs[d]), 32'(e[d]));
        cmp({tag, "_reg_src"}, 32'(regs[s]), 32'(e[s]));
        tick();
    endtask

    typedef struct {
        bit         d6;
        logic [2:0] s;
        logic [2:0] d;
        logic       sw;
        int         lat;
        logic       err;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int acc_cyc [3];
        int k, cyc;
        logic acc;
        rst = 1'b1; v8 = 1'b1; v6 = 1'b1; src = 3'd2; dst = 3'd5; swp = 1'b0; ld = 1'b0;
        for (int i = 0; i < 8; i++) ld_val[i] = 8'h00;

        vecs[0] = '{0, 3'd0, 3'd7, 1'b0, 3, 1'b0};
        vecs[1] = '{0, 3'd3, 3'd3, 1'b0, 3, 1'b0};
        vecs[2] = '{0, 3'd4, 3'd4, 1'b1, 5, 1'b0};
        vecs[3] = '{0, 3'd7, 3'd0, 1'b1, 5, 1'b0};
        vecs[4] = '{1, 3'd5, 3'd5, 1'b1, 5, 1'b0};
        vecs[5] = '{1, 3'd6, 3'd0, 1'b0, 1, 1'b1};
        vecs[6] = '{1, 3'd0, 3'd6, 1'b1, 1, 1'b1};
        vecs[7] = '{1, 3'd7, 3'd7, 1'b1, 1, 1'b1};

        // Reset held two cycles with a request pending
        tick(); tick();
        cmp("rst_ready", 32'(rdy8), 32'(1));
        cmp("rst_rd", 32'(rd8), 32'(0));
        cmp("rst_wr", 32'(wr8), 32'(0));
        cmp("rst_bus", 32'(bus8), 32'(0));
        cmp("rst_done", 32'(done8), 32'(0));
        cmp("rst_err", 32'(err8), 32'(0));
        rst = 1'b0; v8 = 1'b0; v6 = 1'b0;
        tick();
        cmp("post_rst_ready", 32'(rdy8), 32'(1));
        cmp("post_rst_no_accept", 32'(rd8), 32'(0));

        // Copy 2 -> 5
        randomize_ld(); ld_val[2] = 8'hA5; load_regs();
        src = 3'd2; dst = 3'd5; swp = 1'b0; v8 = 1'b1;
        tick(); v8 = 1'b0;
        cmp("copy_rd", 32'(rd8), 32'h04);
        tick();
        cmp("copy_wr", 32'(wr8), 32'h20);
        cmp("copy_bus", 32'(bus8), 32'hA5);
        tick();
        cmp("copy_done", 32'(done8), 32'(1));
        cmp("copy_err", 32'(err8), 32'(0));
        cmp("copy_reg5", 32'(regs[5]), 32'hA5);
        tick();
        cmp("copy_bus_hold", 32'(bus8), 32'hA5);

        // Swap 1 <-> 6
        randomize_ld(); ld_val[1] = 8'h3C; ld_val[6] = 8'hC3; load_regs();
        src = 3'd1; dst = 3'd6; swp = 1'b1; v8 = 1'b1;
        tick(); v8 = 1'b0;
        cmp("swap_rd_a", 32'(rd8), 32'h02);
        tick();
        cmp("swap_rd_b", 32'(rd8), 32'h40);
        tick();
        cmp("swap_wr_b", 32'(wr8), 32'h40);
        cmp("swap_bus_b", 32'(bus8), 32'h3C);
        tick();
        cmp("swap_wr_a", 32'(wr8), 32'h02);
        cmp("swap_bus_a", 32'(bus8), 32'hC3);
        tick();
        cmp("swap_done", 32'(done8), 32'(1));
        cmp("swap_reg1", 32'(regs[1]), 32'hC3);
        cmp("swap_reg6", 32'(regs[6]), 32'h3C);
        tick();

        // Invalid select on the 6-slice instance
        src = 3'd7; dst = 3'd0; swp = 1'b0; v6 = 1'b1;
        tick(); v6 = 1'b0;
        cmp("inv_done", 32'(done6), 32'(1));
        cmp("inv_err", 32'(err6), 32'(1));
        cmp("inv_strobes", 32'({rd6, wr6}), 32'(0));
        tick();
        cmp("inv_done_pulse", 32'(done6), 32'(0));
        cmp("inv_ready", 32'(rdy6), 32'(1));

        // Reset asserted during WR_B of a swap
        src = 3'd1; dst = 3'd6; swp = 1'b1; v8 = 1'b1;
        tick(); v8 = 1'b0;
        tick(); tick();
        cmp("rstmid_in_wrb", 32'(wr8), 32'h40);
        rst = 1'b1;
        tick();
        cmp("rstmid_strobes", 32'({rd8, wr8}), 32'(0));
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            cmp("rstmid_no_done", 32'(done8), 32'(0));
            cmp("rstmid_no_wr", 32'(wr8), 32'(0));
        end

        // Back-to-back copies with valid held high
        randomize_ld(); load_regs();
        k = 0; cyc = 0;
        while (k < 3 && cyc < 60) begin
            src = 3'(2 * k); dst = 3'(2 * k + 1); swp = 1'b0; v8 = 1'b1;
            acc = rdy8;
            tick();
            cyc++;
            if (acc) begin
                acc_cyc[k] = cyc;
                k++;
            end
        end
        v8 = 1'b0;
        cmp("b2b_accepts", 32'(k), 32'(3));
        if (k == 3) begin
            cmp("b2b_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'(4));
            cmp("b2b_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'(4));
        end
        repeat (5) tick();
        cmp("b2b_reg1", 32'(regs[1]), 32'(ld_val[0]));
        cmp("b2b_reg3", 32'(regs[3]), 32'(ld_val[2]));
        cmp("b2b_reg5", 32'(regs[5]), 32'(ld_val[4]));

        for (int i = 0; i < 8; i++)
            xfer(vecs[i].d6, vecs[i].s, vecs[i].d, vecs[i].sw, vecs[i].lat, vecs[i].err, $sformatf("vec%0d", i));

        // Randomized requests checked against transfer-level expectations
        for (int i = 0; i < 30; i++) begin
            bit rd6sel;
            logic [2:0] rs, rdd;
            logic rsw, rerr;
            rd6sel = 1'($urandom);
            rs = 3'($urandom_range(0, 7));
            rdd = 3'($urandom_range(0, 7));
            rsw = 1'($urandom);
            rerr = rd6sel && (rs >= 3'd6 || rdd >= 3'd6);
            xfer(rd6sel, rs, rdd, rsw, rerr ? 1 : (rsw ? 5 : 3), rerr, $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
